// File: rtl/rv_pkg.sv
// Shared RV64IF encoding constants: format codes, major opcodes and the
// field bundle handed from the program source to the encoder.
package rv_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_32     = 7'b0111011;
    localparam logic [6:0] LOAD_FP   = 7'b0000111;
    localparam logic [6:0] STORE_FP  = 7'b0100111;
    localparam logic [6:0] OP_FP     = 7'b1010011;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } inst_fields_t;

    function automatic logic fmt_legal(input logic [2:0] fmt);
        return fmt <= FMT_J;
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO; pointers carry an extra wrap bit so full and empty are
// distinguished without a separate occupancy counter.
module inst_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign rdata = mem[rd_ptr[PW-1:0]];

    // Storage is reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[PW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + (PW+1)'(1);
            end
            if (pop && !empty) rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

endmodule

// File: rtl/inst_encoder.sv
// Packs separated RISC-V instruction fields into 32-bit words and streams
// them to instruction memory at sequential word addresses.
module inst_encoder
    import rv_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  in_clear,
    input  logic                  in_valid,
    output logic                  out_ready,
    input  logic [2:0]            in_fmt,
    input  logic [6:0]            in_opcode,
    input  logic [2:0]            in_funct3,
    input  logic [6:0]            in_funct7,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [31:0]           in_imm,
    output logic                  out_valid,
    input  logic                  in_mem_ready,
    output logic [31:0]           out_inst,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_err
);

    inst_fields_t f;
    logic [31:0]  enc_word;
    logic         fmt_ok;
    logic         full;
    logic         empty;
    logic         accept;
    logic         push;
    logic         pop;

    assign f = '{fmt: in_fmt, opcode: in_opcode, funct3: in_funct3, funct7: in_funct7,
                 rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};

    assign fmt_ok = fmt_legal(f.fmt);

    always_comb begin
        enc_word = '0;
        case (fmt_e'(f.fmt))
            FMT_R: enc_word = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
            FMT_I: enc_word = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
            FMT_S: enc_word = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
            FMT_B: enc_word = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                               f.imm[4:1], f.imm[11], f.opcode};
            FMT_U: enc_word = {f.imm[31:12], f.rd, f.opcode};
            FMT_J: enc_word = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12],
                               f.rd, f.opcode};
            default: enc_word = '0;
        endcase
    end

    // Acceptance depends only on fullness; a same-cycle pop never frees a slot early.
    assign out_ready = !full;
    assign out_valid = !empty;
    assign accept    = in_valid && !full;
    assign push      = accept && fmt_ok && !in_clear;
    assign pop       = out_valid && in_mem_ready && !in_clear;

    inst_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (in_clk),
        .rst   (in_rst),
        .clear (in_clear),
        .push  (push),
        .pop   (pop),
        .wdata (enc_word),
        .rdata (out_inst),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            out_addr <= '0;
            out_err  <= 1'b0;
        end else if (in_clear) begin
            out_addr <= '0;
            out_err  <= 1'b0;
        end else begin
            if (pop) out_addr <= out_addr + ADDR_WIDTH'(1);
            out_err <= accept && !fmt_ok;
        end
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Instruction encoder and program streamer for the RV64IF core: the encode-side counterpart of the control-unit decoder. It accepts instructions as separated fields (format, opcode, funct3, funct7, rd, rs1, rs2, immediate) over a valid/ready handshake and packs each into a 32-bit RISC-V word. Encoded words are buffered in a small FIFO and streamed to instruction memory with a sequential word address. It serves as a boot/test program loader ahead of instruction fetch.

## Interface

Parameters:
- FIFO_DEPTH, 4: encoded-word buffer depth; power of two, ≥2.
- ADDR_WIDTH, 10: width of the instruction-memory word address.

Ports:
- in_clk, input, 1: single clock; all state on rising edge.
- in_rst, input, 1: reset, asynchronous and active-high.
- in_clear, input, 1: synchronous flush; empties FIFO, zeroes address.
- in_valid, input, 1: field set valid.
- out_ready, output, 1: encoder can accept a field set (FIFO not full).
- in_fmt, input, 3: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6–7 illegal.
- in_opcode, input, 7: inst[6:0].
- in_funct3, input, 3: inst[14:12].
- in_funct7, input, 7: inst[31:25], R only.
- in_rd / in_rs1 / in_rs2, input, 5 each: register indices.
- in_imm, input, 32: immediate, already sign-correct; bits used per format.
- out_valid, output, 1: out_inst/out_addr hold a word.
- in_mem_ready, input, 1: memory accepts the word this cycle.
- out_inst, output, 32: encoded instruction at FIFO head.
- out_addr, output, ADDR_WIDTH: word address for out_inst.
- out_err, output, 1: one-cycle pulse on an accepted illegal format.

## Operation

- Push: in_valid & out_ready. Legal format → encoded word written to FIFO tail. Illegal format → nothing written, out_err = 1 the next cycle only.
- Encoding (MSB→LSB):
  - R: funct7 | rs2 | rs1 | funct3 | rd | opcode.
  - I: imm[11:0] | rs1 | funct3 | rd | opcode. Shift-immediates carry funct6/funct7 in imm[11:5]; the caller supplies them.
  - S: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | opcode.
  - B: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | opcode; imm[0] ignored.
  - U: imm[31:12] | rd | opcode.
  - J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | opcode; imm[0] ignored.
  - Fields not used by a format are ignored.
- Pop: out_valid & in_mem_ready. Head is removed and the address counter increments by 1, wrapping from 2^ADDR_WIDTH−1 to 0.
- out_ready = !full. Push when full is never accepted, even if a pop occurs in the same cycle.
- Simultaneous push and pop with the FIFO neither full nor empty: both happen, occupancy unchanged.
- Pop when empty: impossible, because out_valid = 0.
- in_clear: FIFO emptied, address = 0, pending out_err cleared. A push or pop in the same cycle is discarded; clear wins.
- in_rst mid-stream: all buffered words are lost; state goes to the reset values immediately.

## Timing

- Reset values: out_valid 0, out_inst 0, out_addr 0, out_err 0, out_ready 1 (FIFO empty).
- Latency: a word pushed at edge N into an empty FIFO has out_valid = 1 after edge N. There is no combinational path from in_* fields to out_inst.
- out_inst, out_addr and out_valid come from registers or FIFO storage and stay stable while out_valid & !in_mem_ready.
- out_ready depends only on FIFO occupancy, not on in_valid or in_mem_ready.
- Throughput: one word per cycle when upstream and downstream are both continuously ready.

## Structure

- A shared package rv_pkg holds:
  - format codes FMT_R..FMT_J;
  - the 7-bit opcode constants (OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM_32, OP_32, LOAD_FP, STORE_FP, OP_FP), shared with the decoder.
- Sub-module inst_fifo: synchronous FIFO, parameterised by width and depth, with full/empty flags and pointers carrying an extra wrap bit.
- The encoder mux is combinational in the top level, in front of inst_fifo.

## Test plan

- ADDI x1,x0,5 (fmt I, op 0010011, f3 0, rd 1, imm 5) → out_inst 0x00500093, out_addr 0.
- ADD x3,x1,x2 then SW x2,8(x1), back to back with memory ready → 0x002081B3 at addr 0, then 0x0020A423 at addr 1, one per cycle.
- BEQ x1,x2,+8 → 0x00208463. JAL x1,+16 → 0x010000EF. LUI x5 with imm 0x12345000 → 0x123452B7.
- Hold in_mem_ready = 0 and push FIFO_DEPTH words: out_ready falls after the 4th; a 5th push with in_valid held is not taken. Release memory: words drain in order at addr 0..3, then the 5th is accepted.
- Push fmt 6 → no word written, out_err high for exactly one cycle. Separately, preload out_addr to 1023 (ADDR_WIDTH 10) and pop one word → the next address is 0.
- in_clear, and separately in_rst, asserted with 3 words queued → out_valid 0 next cycle, out_addr 0; the next push appears at addr 0.
